// File: rtl/nonce_scanner.sv
// Nonce-sweep controller: inserts successive nonces into a header template, launches
// one hash per nonce on the external core and reports the first digest meeting target.
module nonce_scanner #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [639:0]       header_in,
    input  logic [255:0]       target,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    output logic               core_start,
    output logic [639:0]       core_header,
    input  logic               core_done,
    input  logic [255:0]       core_digest,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic [255:0]       golden_digest,
    output logic [31:0]        hash_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NONCE_W-1:0]   nonce_q;
    logic [NONCE_W-1:0]   end_q;
    logic [255:0]         target_q;
    logic [255:0]         dig_q;
    logic [639:0]         core_header_q;
    logic                 busy_q, done_q, core_start_q, found_q;
    logic [NONCE_W-1:0]   golden_nonce_q;
    logic [255:0]         golden_digest_q;
    logic [31:0]          hash_count_q;

    logic [255:0]         dig_value;
    logic                 hit;
    logic                 last_nonce;
    logic [NONCE_W-1:0]   nonce_inc;
    logic                 unused_nonce_field;

    // The template's own nonce field is always overwritten by the swept nonce.
    assign unused_nonce_field = ^header_in[31:0];

    function automatic logic [31:0] nonce_le(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

    // Digest arrives as a byte string; its last byte is the most significant.
    for (genvar gi = 0; gi < 32; gi++) begin : g_byte_rev
        assign dig_value[gi*8 +: 8] = dig_q[(31-gi)*8 +: 8];
    end

    assign hit        = (dig_value <= target_q);
    assign last_nonce = (nonce_q == end_q);
    assign nonce_inc  = nonce_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort)          state_d = S_IDLE;
                else if (core_done) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (abort || hit || last_nonce) state_d = S_IDLE;
                else                            state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            nonce_q         <= '0;
            end_q           <= '0;
            target_q        <= '0;
            dig_q           <= '0;
            core_header_q   <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            core_start_q    <= 1'b0;
            found_q         <= 1'b0;
            golden_nonce_q  <= '0;
            golden_digest_q <= '0;
            hash_count_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != S_IDLE);
            core_start_q <= (state_d == S_ISSUE);
            done_q       <= (state_q != S_IDLE) && (state_d == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        core_header_q   <= {header_in[639:32], nonce_le(nonce_start)};
                        nonce_q         <= nonce_start;
                        end_q           <= nonce_end;
                        target_q        <= target;
                        found_q         <= 1'b0;
                        golden_nonce_q  <= '0;
                        golden_digest_q <= '0;
                        hash_count_q    <= '0;
                    end
                end
                S_WAIT: begin
                    if (core_done && !abort) dig_q <= core_digest;
                end
                S_CHECK: begin
                    if (!abort) begin
                        hash_count_q <= hash_count_q + 32'd1;
                        if (hit) begin
                            found_q         <= 1'b1;
                            golden_nonce_q  <= nonce_q;
                            golden_digest_q <= dig_q;
                        end else if (!last_nonce) begin
                            // Header low word changes only here, so it is stable while the core runs.
                            nonce_q             <= nonce_inc;
                            core_header_q[31:0] <= nonce_le(nonce_inc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_start    = core_start_q;
    assign core_header   = core_header_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign golden_nonce  = golden_nonce_q;
    assign golden_digest = golden_digest_q;
    assign hash_count    = hash_count_q;

endmodule
